// File: rtl/line_window_buffer.sv
// line_window_buffer: streaming line buffer between grayscale and sobel stages.
// Pops one pixel per transfer in raster order and pushes one vertical column of
// WIN_ROWS pixels centred on the current output pixel. Out-of-frame rows are
// zero (BORDER_MODE=0) or replicate the nearest valid row (BORDER_MODE=1).
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   in_dout     upstream FWFT FIFO data
//   in_empty    upstream FIFO empty
//   in_rd_en    upstream pop (combinational)
//   out_din     column; slice i = row r-H+i, slice 0 (top row) in the low bits
//   out_full    downstream FIFO full
//   out_wr_en   downstream push (registered)
//   frame_done  one-cycle pulse with the last out_wr_en of a frame
module line_window_buffer #(
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned IMG_WIDTH   = 720,
    parameter int unsigned IMG_HEIGHT  = 540,
    parameter int unsigned WIN_ROWS    = 3,
    parameter int unsigned BORDER_MODE = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DWIDTH-1:0]          in_dout,
    input  logic                       in_empty,
    output logic                       in_rd_en,
    output logic [DWIDTH*WIN_ROWS-1:0] out_din,
    input  logic                       out_full,
    output logic                       out_wr_en,
    output logic                       frame_done
);

    localparam int unsigned H      = (WIN_ROWS - 1) / 2;
    localparam int unsigned NL     = WIN_ROWS - 1;
    localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned SLOT_W = (NL > 1) ? $clog2(NL) : 1;
    localparam int unsigned OUT_W  = DWIDTH * WIN_ROWS;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0]  FILL_LAST = ROW_W'(H - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NL - 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [COL_W-1:0]   col, col_nxt;
    logic [ROW_W-1:0]   in_row, in_row_nxt;
    logic [ROW_W-1:0]   out_row, out_row_nxt;
    logic [SLOT_W-1:0]  wr_slot, wr_slot_nxt;
    logic               wr_en_nxt;
    logic               done_nxt;
    logic [OUT_W-1:0]   din_nxt;
    logic [OUT_W-1:0]   column_c;
    logic               mem_we_c;
    logic               col_last_c;
    logic [SLOT_W-1:0]  slot_inc_c;

    // Line memories, one slot per stored row, reused circularly.
    logic [DWIDTH-1:0]  mem [NL][IMG_WIDTH];

    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem[wr_slot][col] <= in_dout;
        end
    end

    // Assemble the column for (out_row, col). Rows are located by their distance
    // back from the row currently being written; in FLUSH that row is one past
    // the frame, so every needed row is already stored.
    always_comb begin
        int               cur_row;
        int               r;
        int               d;
        int               s;
        logic             use_row;
        logic [DWIDTH-1:0] pix;
        column_c = '0;
        cur_row  = (state == ST_RUN) ? int'(in_row) : int'(IMG_HEIGHT);
        for (int i = 0; i < int'(WIN_ROWS); i++) begin
            pix     = '0;
            use_row = 1'b1;
            r       = int'(out_row) - int'(H) + i;
            if (r < 0) begin
                use_row = (BORDER_MODE == 1);
                r       = 0;
            end else if (r > int'(IMG_HEIGHT) - 1) begin
                use_row = (BORDER_MODE == 1);
                r       = int'(IMG_HEIGHT) - 1;
            end
            d = cur_row - r;
            s = int'(wr_slot) + int'(NL) - d;
            if (s >= int'(NL)) begin
                s = s - int'(NL);
            end
            if (use_row) begin
                if (d == 0) begin
                    pix = in_dout;
                end else if ((d > 0) && (d <= int'(NL))) begin
                    pix = mem[SLOT_W'(s)][col];
                end
            end
            column_c[i*DWIDTH +: DWIDTH] = pix;
        end
    end

    // Next-state, counters, pop and push control.
    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        in_row_nxt  = in_row;
        out_row_nxt = out_row;
        wr_slot_nxt = wr_slot;
        wr_en_nxt   = 1'b0;
        done_nxt    = 1'b0;
        din_nxt     = out_din;
        in_rd_en    = 1'b0;
        mem_we_c    = 1'b0;
        col_last_c  = (col == COL_LAST);
        slot_inc_c  = (wr_slot == SLOT_LAST) ? '0 : wr_slot + SLOT_W'(1);

        unique case (state)
            ST_FILL: begin
                in_rd_en = !in_empty;
                if (!in_empty) begin
                    mem_we_c = 1'b1;
                    col_nxt  = col + COL_W'(1);
                    if (col_last_c) begin
                        col_nxt     = '0;
                        in_row_nxt  = in_row + ROW_W'(1);
                        wr_slot_nxt = slot_inc_c;
                        if (in_row == FILL_LAST) begin
                            state_nxt = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                in_rd_en = !in_empty && !out_full;
                if (!in_empty && !out_full) begin
                    mem_we_c  = 1'b1;
                    wr_en_nxt = 1'b1;
                    din_nxt   = column_c;
                    col_nxt   = col + COL_W'(1);
                    if (col_last_c) begin
                        col_nxt     = '0;
                        wr_slot_nxt = slot_inc_c;
                        out_row_nxt = out_row + ROW_W'(1);
                        if (in_row == ROW_LAST) begin
                            in_row_nxt = '0;
                            state_nxt  = ST_FLUSH;
                        end else begin
                            in_row_nxt = in_row + ROW_W'(1);
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (!out_full) begin
                    wr_en_nxt = 1'b1;
                    din_nxt   = column_c;
                    col_nxt   = col + COL_W'(1);
                    if (col_last_c) begin
                        col_nxt = '0;
                        if (out_row == ROW_LAST) begin
                            out_row_nxt = '0;
                            wr_slot_nxt = '0;
                            done_nxt    = 1'b1;
                            state_nxt   = ST_FILL;
                        end else begin
                            out_row_nxt = out_row + ROW_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_FILL;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_FILL;
            col        <= '0;
            in_row     <= '0;
            out_row    <= '0;
            wr_slot    <= '0;
            out_wr_en  <= 1'b0;
            out_din    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            in_row     <= in_row_nxt;
            out_row    <= out_row_nxt;
            wr_slot    <= wr_slot_nxt;
            out_wr_en  <= wr_en_nxt;
            out_din    <= din_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: directed bench for line_window_buffer on a 4x3 image
// with a 3-row window; two instances (zero and replicate borders) share stimulus.
module tb_line_window_buffer;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 4;
    localparam int unsigned IH = 3;
    localparam int unsigned WR = 3;
    localparam int unsigned CW = DW * WR;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_dout = '0;
    logic          in_empty = 1'b1;
    logic          out_full = 1'b0;
    logic          rd0, rd1, we0, we1, fd0, fd1;
    logic [CW-1:0] din0, din1;

    always #5 clock = ~clock;

    line_window_buffer #(
        .DWIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .WIN_ROWS(WR), .BORDER_MODE(0)
    ) u_dut0 (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
        .in_rd_en(rd0), .out_din(din0), .out_full(out_full),
        .out_wr_en(we0), .frame_done(fd0)
    );

    line_window_buffer #(
        .DWIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .WIN_ROWS(WR), .BORDER_MODE(1)
    ) u_dut1 (
        .clock(clock), .reset(reset), .in_dout(in_dout), .in_empty(in_empty),
        .in_rd_en(rd1), .out_din(din1), .out_full(out_full),
        .out_wr_en(we1), .frame_done(fd1)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] src[$];
    logic [CW-1:0] cap0[$];
    logic [CW-1:0] cap1[$];
    int            fd0_at[$];
    int            fd1_at[$];
    int            pop_cycles[$];
    int            pops = 0;
    int            bp_viol = 0;
    int            rd_diverge = 0;
    int            cyc = 0;
    bit            prev_full = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference column from the pixel formula; no storage involved.
    function automatic logic [CW-1:0] exp_col(input int r, input int c, input bit mode,
                                              input int off);
        logic [CW-1:0] v;
        int            rr;
        v = '0;
        for (int i = 0; i < 3; i++) begin
            rr = r - 1 + i;
            if (rr < 0)       rr = mode ? 0 : -1;
            else if (rr > 2)  rr = mode ? 2 : -1;
            if (rr >= 0) v[i*8 +: 8] = 8'(16 * rr + c + off);
        end
        return v;
    endfunction

    function automatic logic [CW-1:0] cap_at(input bit which, input int idx);
        if (which == 1'b0) return (idx < cap0.size()) ? cap0[idx] : '1;
        return (idx < cap1.size()) ? cap1[idx] : '1;
    endfunction

    task automatic load_frame(input int off);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                src.push_back(8'(16 * r + c + off));
    endtask

    // One clock: drive at negedge, sample #1 later, pop on the posedge.
    task automatic step(input bit gate_empty, input int full_pct);
        bit do_pop;
        @(negedge clock);
        out_full = (full_pct > 0) && (int'($urandom_range(99)) < full_pct);
        in_empty = (src.size() == 0) || gate_empty;
        in_dout  = (src.size() != 0) ? src[0] : '0;
        #1;
        if (we0) begin
            cap0.push_back(din0);
            if (prev_full) bp_viol++;
        end
        if (we1) begin
            cap1.push_back(din1);
            if (prev_full) bp_viol++;
        end
        if (fd0) fd0_at.push_back(cap0.size());
        if (fd1) fd1_at.push_back(cap1.size());
        if (rd0 !== rd1) rd_diverge++;
        do_pop    = rd0;
        prev_full = out_full;
        @(posedge clock);
        if (do_pop && src.size() != 0) begin
            void'(src.pop_front());
            pops++;
            pop_cycles.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic run_until(input int want, input bit toggle, input int full_pct,
                             input string tag);
        int n = 0;
        while (cap0.size() < want && n < 500) begin
            step(toggle && cyc[0], full_pct);
            n++;
        end
        repeat (8) step(1'b0, 0);
        check({tag, "_writes0"}, 64'(cap0.size()), 64'(want));
        check({tag, "_writes1"}, 64'(cap1.size()), 64'(want));
    endtask

    task automatic check_frame(input string tag, input int base, input int off);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("%s_z%0d", tag, k), 64'(cap_at(1'b0, base + k)),
                  64'(exp_col(k / 4, k % 4, 1'b0, off)));
            check($sformatf("%s_r%0d", tag, k), 64'(cap_at(1'b1, base + k)),
                  64'(exp_col(k / 4, k % 4, 1'b1, off)));
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset    = 1'b0;
        in_empty = 1'b1;
        out_full = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_wr_en", 64'(we0), 64'(0));
        check("rst_din", 64'(din0), 64'(0));
        check("rst_done", 64'(fd0), 64'(0));
        check("rst_rd_en", 64'(rd0), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        src.delete();
        cap0.delete();
        cap1.delete();
        fd0_at.delete();
        fd1_at.delete();
        pop_cycles.delete();
        pops      = 0;
        cyc       = 0;
        prev_full = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Plain frame, sink never full.
        apply_reset();
        load_frame(0);
        run_until(12, 1'b0, 0, "s1");
        check("s1_first", 64'(cap_at(1'b0, 0)), 64'h100000);
        check("s1_r1c2", 64'(cap_at(1'b0, 6)), 64'h221202);
        check("s1_last", 64'(cap_at(1'b0, 11)), 64'h002313);
        check("s1_rep_first", 64'(cap_at(1'b1, 0)), 64'h100000);
        check("s1_rep_r0c1", 64'(cap_at(1'b1, 1)), 64'h110101);
        check("s1_rep_last", 64'(cap_at(1'b1, 11)), 64'h232313);
        check("s1_done_cnt", 64'(fd0_at.size()), 64'(1));
        check("s1_done_at", 64'((fd0_at.size() > 0) ? fd0_at[0] : -1), 64'(12));
        check("s1_done_at1", 64'((fd1_at.size() > 0) ? fd1_at[0] : -1), 64'(12));
        check_frame("s1", 0, 0);

        // Sink full from the start: only row 0 is absorbed.
        apply_reset();
        load_frame(0);
        repeat (20) step(1'b0, 100);
        check("s3_pops", 64'(pops), 64'(4));
        check("s3_no_writes", 64'(cap0.size()), 64'(0));
        @(negedge clock);
        #1;
        check("s3_rd_blocked", 64'(rd0), 64'(0));
        run_until(12, 1'b0, 0, "s3");
        check_frame("s3", 0, 0);

        // Bubbly source and random backpressure.
        apply_reset();
        load_frame(0);
        run_until(12, 1'b1, 30, "s4");
        check_frame("s4", 0, 0);
        check("s4_bp_viol", 64'(bp_viol), 64'(0));

        // Reset in the middle of a frame.
        apply_reset();
        load_frame(0);
        begin
            int n = 0;
            while (cap0.size() < 6 && n < 100) begin
                step(1'b0, 0);
                n++;
            end
        end
        check("s5_pre", 64'(cap0.size()), 64'(6));
        #2;
        reset = 1'b0;
        #1;
        check("s5_wr_clear", 64'(we0), 64'(0));
        check("s5_din_clear", 64'(din0), 64'(0));
        apply_reset();
        load_frame(0);
        run_until(12, 1'b0, 0, "s5");
        check_frame("s5", 0, 0);

        // Two frames queued back to back.
        apply_reset();
        load_frame(0);
        load_frame(128);
        run_until(24, 1'b0, 0, "s6");
        check_frame("s6a", 0, 0);
        check_frame("s6b", 12, 128);
        check("s6_pops", 64'(pops), 64'(24));
        check("s6_flush_gap",
              64'((pop_cycles.size() > 12) ? pop_cycles[12] - pop_cycles[11] : -1), 64'(5));
        check("s6_done_cnt", 64'(fd0_at.size()), 64'(2));
        check("s6_done_1", 64'((fd0_at.size() > 0) ? fd0_at[0] : -1), 64'(12));
        check("s6_done_2", 64'((fd0_at.size() > 1) ? fd0_at[1] : -1), 64'(24));
        check("s6_done_cnt1", 64'(fd1_at.size()), 64'(2));

        check("rd_match", 64'(rd_diverge), 64'(0));
        check("bp_total", 64'(bp_viol), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Streaming line-buffer stage that sits between the RGB-to-grayscale stage and the sobel stage in dut_system.
- Takes one pixel per transfer in raster order from an upstream FWFT FIFO.
- Emits one vertical column of WIN_ROWS pixels per transfer, centred on the current output pixel, into a downstream FIFO.
- Rows are stored internally and reused, so each input pixel is read exactly once.
- Image rows outside the frame are filled according to BORDER_MODE.

Parameters:
- DWIDTH, 8, bits per pixel.
- IMG_WIDTH, 720, pixels per row; must be ≥ 2.
- IMG_HEIGHT, 540, rows per frame; must be ≥ H+1.
- WIN_ROWS, 3, window height; odd, 3..7. H = (WIN_ROWS-1)/2.
- BORDER_MODE, 0, out-of-frame row fill: 0 = zero, 1 = replicate nearest valid row.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- in_dout  in  DWIDTH  upstream FIFO data (first-word fall-through).
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  WIN-independent 1  upstream pop; combinational.
- out_din  out  DWIDTH*WIN_ROWS  column; slice i = pixel at row r-H+i, same column. Slice 0 = top row, in the low bits.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  downstream push; registered.
- frame_done  out  1  one-cycle pulse, coincident with the last out_wr_en of a frame.

Behaviour:
- Reset (reset=0, async): state=FILL, col=0, in_row=0, out_row=0; out_wr_en=0, out_din=0, frame_done=0. Line-buffer contents are not cleared and are don't-care.
- Storage: WIN_ROWS-1 line memories of IMG_WIDTH x DWIDTH, written circularly by row.
- Counters:
  - col wraps IMG_WIDTH-1 -> 0 and increments the row counter.
  - All counters are sized $clog2 of their maximum value.
- States:
  - FILL: input rows 0..H-1.
    - in_rd_en = !in_empty; out_full is ignored; no output.
    - After the last pixel of row H-1 -> RUN.
  - RUN: input rows H..IMG_HEIGHT-1.
    - in_rd_en = !in_empty && !out_full.
    - Each pop produces a column for out_row = in_row-H at column col.
    - After the pop of pixel (IMG_HEIGHT-1, IMG_WIDTH-1) -> FLUSH.
  - FLUSH: outputs rows IMG_HEIGHT-H..IMG_HEIGHT-1 with no input.
    - in_rd_en=0, even if the next frame's data is present.
    - One column per cycle while !out_full.
    - After the final column -> FILL, counters reset to 0.
- Latency: out_wr_en/out_din are registered exactly 1 cycle after the enabling pop (RUN) or enabling cycle (FLUSH).
  - out_wr_en=0 on any cycle with no pop/flush step.
  - out_din holds its last value while out_wr_en=0.
- Backpressure: out_wr_en is only ever asserted when out_full was 0 on the preceding cycle. No column is dropped or duplicated.
- Border handling for rows r-H+i < 0 or > IMG_HEIGHT-1:
  - BORDER_MODE=0: slice = 0.
  - BORDER_MODE=1: slice = pixel of row 0 or row IMG_HEIGHT-1 respectively, same column.
- Horizontal borders are not handled here; that is the downstream sobel stage's job.
- Count: exactly IMG_WIDTH*IMG_HEIGHT out_wr_en pulses per frame.
- Frames: frames are back-to-back; a new frame begins with the first pop after FLUSH completes. frame_done pulses once per frame.
- Async reset mid-frame: outputs clear immediately, the partial frame is discarded, and the next pixel popped is treated as (0,0).
- Simultaneous events: in_empty=1 and out_full=1 together -> stall; state and counters hold.

Test Plan:
- DWIDTH=8, IMG_WIDTH=4, IMG_HEIGHT=3, WIN_ROWS=3. Pixel (r,c) = 16*r+c. BORDER_MODE=0, sink never full:
  - first out_din=24'h100000;
  - (1,2)=24'h221202;
  - last (2,3)=24'h002313;
  - exactly 12 writes; frame_done with the 12th.
- BORDER_MODE=1, same stimulus:
  - (0,0)=24'h100000;
  - (0,1)=24'h110101;
  - (2,3)=24'h232313;
  - 12 writes.
- out_full held 1 from start:
  - exactly 4 pops (row 0) then in_rd_en=0, out_wr_en=0;
  - release -> identical 12-column sequence to scenario 1, no gaps in content.
- in_empty toggled every other cycle and out_full randomly asserted (~30%):
  - column sequence identical to scenario 1;
  - out_wr_en never follows an out_full=1 cycle.
- reset pulsed low after the 6th output:
  - out_wr_en=0 within the same cycle;
  - a new full frame then yields the scenario 1 sequence exactly.
- Two frames back-to-back in the source FIFO:
  - no pops during FLUSH;
  - 24 writes, second frame's values correct;
  - frame_done pulses twice.
